rr_mux: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes. It is the successor to the fixed 4:1 combinational select mux. Each cycle it picks one requesting input channel, either by rotating round-robin priority or by an explicit select, and places the chosen beat in a one-deep output register. It sits between several producer streams and a single shared consumer, such as a shared bus or a FIFO write port.

---
 rtl/mux_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rr_mux.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants, lock-FSM state type and a clog2 helper
//                for the rr_mux channel multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Encoding of the rr_mux mode input
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Packet-lock FSM states
    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Ceiling log2; only used for channel counts of two or more
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotating-priority arbiter. Channel prio has
//                the highest priority, then prio+1, wrapping at NCH-1 to 0.
//                The grant is one-hot, or all-zero with no requests.
//                prio must be below NCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int SW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  prio,
    output logic [NCH-1:0] grant
);

    logic [NCH-1:0] w_rot;
    logic [NCH-1:0] w_first;

    // Rotate requests so that channel prio sits at bit 0
    assign w_rot   = NCH'({req, req} >> prio);

    // Keep only the lowest set bit of the rotated request vector
    assign w_first = w_rot & (~w_rot + NCH'(1));

    // Rotate the one-hot result back to absolute channel positions
    assign grant   = NCH'(({w_first, w_first} << prio) >> NCH);

endmodule
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux
//  Description : NCH-channel, DW-bit registered multiplexer with valid/ready
//                handshakes. Arbitrates round-robin (mode=0) or takes an
//                explicit channel select (mode=1), and holds the chosen beat
//                in a one-deep output register.
//                Optional feature macro: RR_MUX_LOCK_EN - keeps the grant on
//                one channel until a beat with din_last=1 is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux
    import mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int SW  = clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [NCH-1:0]    din_valid,
    input  logic [NCH*DW-1:0] din,
    input  logic [NCH-1:0]    din_last,
    output logic [NCH-1:0]    din_ready,
    output logic              dout_valid,
    output logic [DW-1:0]     dout,
    output logic [SW-1:0]     dout_ch,
    input  logic              dout_ready
);

    logic [NCH-1:0] w_sel_mask;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_grant;
    logic [NCH-1:0] w_ready;
    logic           w_load;
    logic           w_acc;
    logic           w_adv;
    logic [SW-1:0]  w_acc_ch;
    logic [DW-1:0]  w_acc_data;
    logic [SW-1:0]  w_next_prio;

    logic [SW-1:0]  r_prio;
    logic           r_dout_valid;
    logic [DW-1:0]  r_dout;
    logic [SW-1:0]  r_dout_ch;

    // One-hot decode of sel; values of NCH and above select nothing
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_sel
            assign w_sel_mask[i] = (sel == SW'(i));
        end
    endgenerate

`ifdef RR_MUX_LOCK_EN
    lock_state_t    r_state;
    logic [SW-1:0]  r_lock_ch;
    logic [NCH-1:0] w_lock_mask;
    logic           w_acc_last;

    // One-hot decode of the locked channel
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lock
            assign w_lock_mask[i] = (r_lock_ch == SW'(i));
        end
    endgenerate
`else
    // din_last has no function without the packet lock
    logic w_unused_last;
    assign w_unused_last = ^din_last;
`endif

    // Requests seen by the arbiter: all channels, the selected one, or the locked one
    always_comb begin
        w_req = din_valid;
        if (mode == MODE_FIXED) begin
            w_req = din_valid & w_sel_mask;
        end
`ifdef RR_MUX_LOCK_EN
        if (r_state == ST_LOCKED) begin
            w_req = din_valid & w_lock_mask;
        end
`endif
    end

    rr_arbiter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_arb (
        .req   (w_req),
        .prio  (r_prio),
        .grant (w_grant)
    );

    // The register can take a new beat when empty or draining this cycle
    assign w_load    = !r_dout_valid || dout_ready;
    assign w_ready   = w_grant & {NCH{w_load & rst_n}};
    assign w_acc     = |w_ready;
    assign din_ready = w_ready;

    // Encode the granted channel and pick its data (and last flag)
    always_comb begin
        w_acc_ch   = '0;
        w_acc_data = '0;
`ifdef RR_MUX_LOCK_EN
        w_acc_last = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_acc_ch   = SW'(i);
                w_acc_data = din[i*DW +: DW];
`ifdef RR_MUX_LOCK_EN
                w_acc_last = din_last[i];
`endif
            end
        end
    end

    // Next priority is the channel after the one accepted, modulo NCH
    assign w_next_prio = (w_acc_ch == SW'(NCH - 1)) ? '0 : w_acc_ch + SW'(1);

`ifdef RR_MUX_LOCK_EN
    // Rotate only at packet boundaries; a single-beat packet in fixed mode leaves prio alone
    assign w_adv = w_acc && w_acc_last && ((mode == MODE_RR) || (r_state == ST_LOCKED));
`else
    assign w_adv = w_acc && (mode == MODE_RR);
`endif

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_prio       <= '0;
        end else begin
            if (w_acc) begin
                r_dout_valid <= 1'b1;
                r_dout       <= w_acc_data;
                r_dout_ch    <= w_acc_ch;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            if (w_adv) begin
                r_prio <= w_next_prio;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    // Packet lock: stay on a channel from its first non-last beat until its last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ARB;
            r_lock_ch <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_acc && !w_acc_last) begin
                        r_state   <= ST_LOCKED;
                        r_lock_ch <= w_acc_ch;
                    end
                end
                ST_LOCKED: begin
                    if (w_acc && w_acc_last) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end
`endif

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign dout_ch    = r_dout_ch;

endmodule
`default_nettype wire
